serial_pcm_expander: RTL and testbench

SERIAL_PCM_EXPANDER -- requirements
Module: serial_pcm_expander

---
 rtl/serial_pcm_expander_if.sv | 29 ++
 rtl/serial_pcm_expander.sv | 115 +++++++++++
 tb/tb_serial_pcm_expander.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pcm_expander_if.sv
// Bus bundle for serial_pcm_expander.
//   master : drives the serial side (sen, sync, sdata), observes results
//   slave  : the expander; receives serial bits, drives the decoded word
//   sen        bit strobe
//   sync       frame marker (current bit is the MSB of a new word)
//   sdata      serial log-PCM data, MSB first
//   pcm_linear expanded word, [12]=sign, [11:0]=magnitude
//   pcm_log    last complete log word
//   pcm_valid  one-cycle pulse on each new word
//   frame_err  one-cycle pulse when a word is cut short by sync
interface serial_pcm_expander_if;
    logic        sen;
    logic        sync;
    logic        sdata;
    logic [12:0] pcm_linear;
    logic [7:0]  pcm_log;
    logic        pcm_valid;
    logic        frame_err;

    modport master (
        output sen, sync, sdata,
        input  pcm_linear, pcm_log, pcm_valid, frame_err
    );

    modport slave (
        input  sen, sync, sdata,
        output pcm_linear, pcm_log, pcm_valid, frame_err
    );
endinterface

// File: rtl/serial_pcm_expander.sv
// Serial log-PCM (8-bit, sign/segment/mantissa) to 13-bit sign-magnitude
// linear expander.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_pcm_expander_if.slave (serial in, decoded word out)
// Parameter MIDPOINT: 1 adds a half-step reconstruction offset.
module serial_pcm_expander #(
    parameter bit MIDPOINT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_pcm_expander_if.slave        bus
);

    typedef enum logic [1:0] {IDLE, SHIFT, EMIT} state_t;

    state_t      state, state_nx;
    logic [7:0]  shreg;
    logic [2:0]  cnt;
    logic        load_msb, shift_bit, abort;

    logic [12:0] lin_q;
    logic [7:0]  log_q;
    logic        vld_q, ferr_q;

    // Magnitude expansion: seg 0 is linear with step 2; seg n>=1 places
    // the implied leading 1 above the mantissa and scales by 2^n.
    // Largest result (seg 7, mant 15, midpoint) is 31*128+64 = 4032.
    function automatic logic [11:0] expand(input logic [6:0] c);
        logic [11:0] base, half;
        if (c[6:4] == 3'd0) begin
            expand = {7'd0, c[3:0], MIDPOINT};
        end else begin
            base   = {7'd0, 1'b1, c[3:0]} << c[6:4];
            half   = MIDPOINT ? (12'd1 << (c[6:4] - 3'd1)) : 12'd0;
            expand = base + half;
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        load_msb  = 1'b0;
        shift_bit = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.sen && bus.sync) begin
                    load_msb = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.sen) begin
                    if (bus.sync) begin
                        // early sync: drop the partial word, restart on this bit
                        load_msb = 1'b1;
                        abort    = 1'b1;
                    end else begin
                        shift_bit = 1'b1;
                        if (cnt == 3'd0) state_nx = EMIT;
                    end
                end
            end
            EMIT: begin
                // the finished word is registered on this edge regardless;
                // a sync here overlaps the next word's MSB with the emit
                if (bus.sen && bus.sync) begin
                    load_msb = 1'b1;
                    state_nx = SHIFT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg  <= '0;
            cnt    <= '0;
            lin_q  <= '0;
            log_q  <= '0;
            vld_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            vld_q  <= (state == EMIT);
            ferr_q <= abort;
            if (load_msb) begin
                shreg <= {bus.sdata, 7'd0};
                cnt   <= 3'd6;
            end else if (shift_bit) begin
                shreg[cnt] <= bus.sdata;
                cnt        <= cnt - 3'd1;
            end
            // shreg still holds the finished word here even if load_msb
            // overwrites it on the same edge
            if (state == EMIT) begin
                log_q <= shreg;
                lin_q <= {shreg[7], expand(shreg[6:0])};
            end
        end
    end

    assign bus.pcm_linear = lin_q;
    assign bus.pcm_log    = log_q;
    assign bus.pcm_valid  = vld_q;
    assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_serial_pcm_expander.sv
// Directed bench for serial_pcm_expander: a MIDPOINT=1 and a MIDPOINT=0
// instance share the same serial stimulus.
module tb_serial_pcm_expander;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sen = 1'b0, sync = 1'b0, sdata = 1'b0;

    always #5 clk = ~clk;

    serial_pcm_expander_if if1();
    serial_pcm_expander_if if0();

    assign if1.sen = sen;  assign if1.sync = sync;  assign if1.sdata = sdata;
    assign if0.sen = sen;  assign if0.sync = sync;  assign if0.sdata = sdata;

    serial_pcm_expander #(.MIDPOINT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    serial_pcm_expander #(.MIDPOINT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

    typedef struct {
        logic [7:0]  log;
        logic [12:0] lin;
        int          lat;
    } obs_t;

    typedef struct {
        logic [7:0]  code;
        logic [12:0] lin1;
        logic [12:0] lin0;
    } vec_t;

    obs_t q1[$];
    obs_t q0[$];
    vec_t vt[10];

    int n_cmp = 0, n_bad = 0;
    int tcnt = 0, last_e = -100;
    int ferr1 = 0, ferr0 = 0, ferr_t = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: sample all outputs 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        tcnt++;
        if (if1.pcm_valid) q1.push_back(obs_t'{if1.pcm_log, if1.pcm_linear, tcnt - last_e});
        if (if0.pcm_valid) q0.push_back(obs_t'{if0.pcm_log, if0.pcm_linear, tcnt - last_e});
        if (if1.frame_err) begin ferr1++; ferr_t = tcnt; end
        if (if0.frame_err) ferr0++;
    endtask

    task automatic sbit(input logic s, input logic d);
        sen = 1'b1; sync = s; sdata = d;
        tick();
        sen = 1'b0; sync = 1'b0;
    endtask

    // sen=0 gap cycles; sync/sdata toggle randomly to show they are ignored
    task automatic gap(input int n);
        repeat (n) begin
            sen = 1'b0;
            sync = 1'($urandom_range(0, 1));
            sdata = 1'($urandom_range(0, 1));
            tick();
        end
        sync = 1'b0;
    endtask

    task automatic idle(input int n);
        sen = 1'b0; sync = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_word(input logic [7:0] code, input int maxgap);
        for (int i = 7; i >= 0; i--) begin
            sbit(i == 7, code[i]);
            if (i == 0) last_e = tcnt;
            else gap($urandom_range(0, maxgap));
        end
    endtask

    task automatic expect_w(input int which, input logic [7:0] elog,
                            input logic [12:0] elin, input string nm);
        obs_t o;
        if (which == 1) begin
            chk({nm, " pulse1"}, 32'(q1.size() > 0), 32'd1);
            if (q1.size() == 0) return;
            o = q1.pop_front();
        end else begin
            chk({nm, " pulse0"}, 32'(q0.size() > 0), 32'd1);
            if (q0.size() == 0) return;
            o = q0.pop_front();
        end
        chk({nm, " log"}, 32'(o.log), 32'(elog));
        chk({nm, " lin"}, 32'(o.lin), 32'(elin));
        chk({nm, " latency"}, o.lat, 1);
    endtask

    task automatic expect_empty(input string nm);
        chk({nm, " extra pulses1"}, q1.size(), 0);
        chk({nm, " extra pulses0"}, q0.size(), 0);
    endtask

    // Reference linear-to-log compressor used for the round-trip check.
    function automatic logic [7:0] compress(input logic [12:0] lin);
        logic [11:0] m;
        logic [2:0]  seg;
        m = lin[11:0];
        seg = 3'd0;
        for (int b = 11; b >= 5; b--)
            if (m[b] && seg == 3'd0) seg = 3'(b - 4);
        compress = {lin[12], seg, 4'(m >> ((seg == 3'd0) ? 3'd1 : seg))};
    endfunction

    initial begin
        // code, expected linear MIDPOINT=1, expected linear MIDPOINT=0
        vt[0] = '{8'h00, 13'h0001, 13'h0000};
        vt[1] = '{8'hFF, 13'h1FC0, 13'h1F80};
        vt[2] = '{8'h2A, 13'h006A, 13'h0068};
        vt[3] = '{8'h9F, 13'h103F, 13'h103E};
        vt[4] = '{8'h10, 13'h0021, 13'h0020};
        vt[5] = '{8'h3C, 13'h00E4, 13'h00E0};  // 28<<3 + 4 = 228
        vt[6] = '{8'h80, 13'h1001, 13'h1000};
        vt[7] = '{8'h0F, 13'h001F, 13'h001E};
        vt[8] = '{8'h70, 13'h0840, 13'h0800};
        vt[9] = '{8'hC5, 13'h1542, 13'h1540};  // 21<<6 + 32 = 1376? no: seg4 -> 21<<4 + 8

        // seg4, mant5: (16+5)<<4 = 336, +8 = 344 = 0x158
        vt[9] = '{8'hC5, 13'h1158, 13'h1150};

        // reset state
        repeat (3) tick();
        chk("reset lin1", 32'(if1.pcm_linear), 0);
        chk("reset log1", 32'(if1.pcm_log), 0);
        chk("reset vld1", 32'(if1.pcm_valid), 0);
        chk("reset ferr1", 32'(if1.frame_err), 0);
        chk("reset lin0", 32'(if0.pcm_linear), 0);
        chk("reset vld0", 32'(if0.pcm_valid), 0);
        rst = 1'b0;
        idle(2);

        // stray sen=1/sync=0 bits after reset must not start a word
        sbit(1'b0, 1'b1); sbit(1'b0, 1'b0); sbit(1'b0, 1'b1);
        idle(3);
        expect_empty("pre-sync");

        // table of single words, sent with idle between them
        foreach (vt[k]) begin
            send_word(vt[k].code, 0);
            idle(3);
            expect_w(1, vt[k].code, vt[k].lin1, $sformatf("vec%0d", k));
            expect_w(0, vt[k].code, vt[k].lin0, $sformatf("vec%0d", k));
            expect_empty($sformatf("vec%0d", k));
            chk($sformatf("vec%0d hold log", k), 32'(if1.pcm_log), 32'(vt[k].code));
        end
        chk("table frame_err", ferr1 + ferr0, 0);

        // back-to-back: next MSB with sync lands on each EMIT cycle
        send_word(8'hFF, 0);
        send_word(8'h2A, 0);
        send_word(8'h9F, 0);
        idle(3);
        expect_w(1, 8'hFF, 13'h1FC0, "b2b0");
        expect_w(1, 8'h2A, 13'h006A, "b2b1");
        expect_w(1, 8'h9F, 13'h103F, "b2b2");
        expect_w(0, 8'hFF, 13'h1F80, "b2b0");
        expect_w(0, 8'h2A, 13'h0068, "b2b1");
        expect_w(0, 8'h9F, 13'h103E, "b2b2");
        expect_empty("b2b");
        chk("b2b frame_err", ferr1 + ferr0, 0);

        // random sen gaps of 0-5 cycles; latency still from the bit-0 edge
        for (int r = 0; r < 3; r++) begin
            send_word(8'h2A, 5);
            gap(4);
            expect_w(0, 8'h2A, 13'h0068, "gaps");
            expect_w(1, 8'h2A, 13'h006A, "gaps");
            expect_empty("gaps");
        end

        // early sync: 4 bits of 0xA5 (1010), then a full 0x3C
        begin
            int t0;
            sbit(1'b1, 1'b1); sbit(1'b0, 1'b0); gap(2);
            sbit(1'b0, 1'b1); sbit(1'b0, 1'b0);
            t0 = tcnt;
            send_word(8'h3C, 0);
            idle(3);
            chk("abort ferr count1", ferr1, 1);
            chk("abort ferr count0", ferr0, 1);
            chk("abort ferr timing", ferr_t, t0 + 1);
            expect_w(1, 8'h3C, 13'h00E4, "abort");
            expect_w(0, 8'h3C, 13'h00E0, "abort");
            expect_empty("abort");
        end

        // outputs hold between pulses
        idle(4);
        chk("hold log", 32'(if1.pcm_log), 32'h3C);
        chk("hold lin", 32'(if1.pcm_linear), 32'h00E4);
        chk("hold vld", 32'(if1.pcm_valid), 0);

        // reset mid-word: 5 bits of 0x7E, then async reset
        ferr1 = 0; ferr0 = 0;
        sbit(1'b1, 1'b0); sbit(1'b0, 1'b1); sbit(1'b0, 1'b1);
        sbit(1'b0, 1'b1); sbit(1'b0, 1'b1);
        rst = 1'b1;
        #1;
        chk("async rst lin", 32'(if1.pcm_linear), 0);
        chk("async rst log", 32'(if1.pcm_log), 0);
        idle(2);
        rst = 1'b0;
        sbit(1'b0, 1'b1); sbit(1'b0, 1'b1); sbit(1'b0, 1'b0);
        idle(4);
        expect_empty("rst 7E");
        chk("rst frame_err", ferr1 + ferr0, 0);
        send_word(8'h10, 0);
        idle(3);
        expect_w(1, 8'h10, 13'h0021, "post-rst");
        expect_w(0, 8'h10, 13'h0020, "post-rst");
        expect_empty("post-rst");

        // all 256 codes, both MIDPOINT values, through the reference compressor
        for (int c = 0; c < 256; c++) begin
            obs_t o;
            send_word(8'(c), 0);
            idle(2);
            chk($sformatf("sweep%0d n1", c), q1.size(), 1);
            chk($sformatf("sweep%0d n0", c), q0.size(), 1);
            if (q1.size() > 0) begin
                o = q1.pop_front();
                chk($sformatf("sweep%0d log1", c), 32'(o.log), c);
                chk($sformatf("sweep%0d rt1", c), 32'(compress(o.lin)), c);
            end
            if (q0.size() > 0) begin
                o = q0.pop_front();
                chk($sformatf("sweep%0d log0", c), 32'(o.log), c);
                chk($sformatf("sweep%0d rt0", c), 32'(compress(o.lin)), c);
            end
            q1.delete();
            q0.delete();
        end
        chk("sweep frame_err", ferr1 + ferr0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
